// File: rtl/jpeg_out_pkg.sv
// jpeg_out_pkg
//   Shared definitions for the JPEG entropy-coded byte output stage.
//   Holds the output FSM state encoding, the marker/stuffing byte
//   constants, and a helper that selects one byte of a FIFO word.
package jpeg_out_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SEND,
    ST_STUFF,
    ST_EOI_FF,
    ST_EOI_D9,
    ST_DONE
  } state_e;

  localparam logic [7:0] MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] STUFF_BYTE    = 8'h00;
  localparam logic [7:0] EOI_CODE      = 8'hD9;

  // Byte 0 is the most significant byte of the word (first on the wire).
  function automatic logic [7:0] word_byte(input logic [31:0] word,
                                           input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/jpeg_byte_out.sv
// jpeg_byte_out
//   Pops 32-bit words from an upstream FIFO and serialises them into a
//   byte stream, most significant byte first. Every 0xFF data byte is
//   followed by a stuffed 0x00. On request, once the FIFO is drained,
//   the unstuffed end-of-image marker FF D9 is emitted and eoi_done
//   pulses for one cycle.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   fifo_empty   upstream FIFO holds no words
//   read_req     one-cycle pop request to the FIFO
//   read_data    FIFO word, bits 31:24 are the first byte
//   rdata_valid  read_data valid, one cycle after read_req
//   eoi_req      single-cycle request for the end-of-image marker
//   byte_out     output byte (0x00 while byte_valid is low)
//   byte_valid   byte_out valid
//   byte_ready   downstream accepts the current byte
//   eoi_done     one-cycle pulse after the D9 byte transfers
//   busy         not idle, or an end-of-image marker is still pending
module jpeg_byte_out
  import jpeg_out_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  output logic        read_req,
  input  logic [31:0] read_data,
  input  logic        rdata_valid,
  input  logic        eoi_req,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        eoi_done,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic        eoi_pending_q, eoi_pending_d;

  logic [7:0]  cur_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      word_q        <= '0;
      idx_q         <= '0;
      eoi_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      idx_q         <= idx_d;
      eoi_pending_q <= eoi_pending_d;
    end
  end

  assign cur_byte = word_byte(word_q, idx_q);

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    read_req   = 1'b0;
    byte_valid = 1'b0;
    byte_out   = STUFF_BYTE;
    eoi_done   = 1'b0;

    // A request seen in DONE is a fresh one, so the set term wins.
    eoi_pending_d = eoi_req | (eoi_pending_q & (state_q != ST_DONE));

    case (state_q)
      ST_IDLE: begin
        // Queued data always drains before the marker goes out.
        if (!fifo_empty) begin
          state_d = ST_REQ;
        end else if (eoi_pending_q) begin
          state_d = ST_EOI_FF;
        end
      end

      ST_REQ: begin
        read_req = 1'b1;
        state_d  = ST_WAIT;
      end

      ST_WAIT: begin
        if (rdata_valid) begin
          word_d  = read_data;
          idx_d   = 2'd0;
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        byte_valid = 1'b1;
        byte_out   = cur_byte;
        // Stuffing has priority over ending the word so that a trailing
        // 0xFF still gets its 0x00 before the next pop.
        if (byte_ready) begin
          if (cur_byte == MARKER_PREFIX) begin
            state_d = ST_STUFF;
          end else if (idx_q == 2'd3) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      ST_STUFF: begin
        byte_valid = 1'b1;
        byte_out   = STUFF_BYTE;
        if (byte_ready) begin
          if (idx_q == 2'd3) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_SEND;
          end
        end
      end

      ST_EOI_FF: begin
        byte_valid = 1'b1;
        byte_out   = MARKER_PREFIX;
        if (byte_ready) begin
          state_d = ST_EOI_D9;
        end
      end

      ST_EOI_D9: begin
        byte_valid = 1'b1;
        byte_out   = EOI_CODE;
        if (byte_ready) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        eoi_done = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE) || eoi_pending_q;

endmodule

// File: doc/jpeg_byte_out.md
JPEG_BYTE_OUT -- requirements
Module: jpeg_byte_out

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock.
REQ-002 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have fifo_empty  input  1  upstream 32-bit FIFO holds no words.
REQ-004 SHALL have read_req  output  1  one-cycle pop request to FIFO.
REQ-005 SHALL have read_data  input  32  FIFO word; bits 31:24 are the first byte.
REQ-006 SHALL have rdata_valid  input  1  read_data valid, one cycle after the accepted read_req.
REQ-007 SHALL have eoi_req  input  1  single-cycle pulse: emit end-of-image marker after the FIFO drains.
REQ-008 SHALL have byte_out  output  8  output byte.
REQ-009 SHALL have byte_valid  output  1  byte_out valid.
REQ-010 SHALL have byte_ready  input  1  downstream accepts; a transfer occurs when byte_valid and byte_ready are both high at a clock edge.
REQ-011 SHALL have eoi_done  output  1  one-cycle pulse after the 0xD9 transfer.
REQ-012 SHALL have busy  output  1  high in any state other than IDLE, or while an EOI is pending.

Function
REQ-013 SHALL implement the states IDLE, REQ, WAIT, SEND, STUFF, EOI_FF, EOI_D9 and DONE.
REQ-014 IDLE SHALL go to REQ when fifo_empty=0; else go to EOI_FF if eoi_pending=1; else stay in IDLE. FIFO data takes priority over EOI.
REQ-015 read_req SHALL be high exactly while in REQ, for one cycle; REQ SHALL go unconditionally to WAIT.
REQ-016 WAIT SHALL capture read_data into a 32-bit word register on rdata_valid=1, clear byte index idx to 0, and go to SEND; otherwise it stays in WAIT.
REQ-017 SEND SHALL drive byte_out=word[31-8*idx -: 8] with byte_valid=1.
REQ-018 A SEND transfer SHALL take the first matching action:
  - byte=0xFF: go to STUFF;
  - idx=3: go to IDLE;
  - otherwise: increment idx and stay in SEND.
REQ-019 STUFF SHALL drive byte_out=0x00 with byte_valid=1. On transfer: idx=3 goes to IDLE; otherwise increment idx and return to SEND.
REQ-020 EOI_FF SHALL drive byte_out=0xFF and EOI_D9 SHALL drive byte_out=0xD9, both unstuffed with byte_valid=1. Each advances on transfer: EOI_FF to EOI_D9, EOI_D9 to DONE.
REQ-021 DONE SHALL assert eoi_done for one cycle, clear eoi_pending, and go to IDLE.
REQ-022 eoi_pending SHALL be set by eoi_req in any state, and cleared only in DONE and by reset. An eoi_req arriving while pending is absorbed; it causes no second marker.
REQ-023 byte_valid SHALL be 0 in IDLE, REQ, WAIT and DONE. byte_out SHALL be 0x00 whenever byte_valid=0.
REQ-024 byte_out and byte_valid SHALL stay stable while byte_valid=1 and byte_ready=0 (no retraction).
REQ-025 At most one FIFO word SHALL be outstanding. read_req SHALL never be asserted when fifo_empty=1.
REQ-026 idx SHALL be 2 bits wide and its only terminal value is 3; it never wraps from 3 to 0 during a word.
REQ-027 Throughput SHALL be at most one byte per cycle. Per-word overhead SHALL be exactly 3 non-output cycles (IDLE, REQ, WAIT).

Reset
REQ-028 On rst, state SHALL be IDLE and word, idx and eoi_pending SHALL be 0.
REQ-029 On rst, read_req, byte_valid, eoi_done and busy SHALL be 0 and byte_out SHALL be 0x00.
REQ-030 Reset mid-word SHALL discard the remaining bytes and any pending EOI, with no partial output after deassertion.

Structure
REQ-031 Package jpeg_out_pkg SHALL hold:
  - the state enum;
  - the constants MARKER_PREFIX=8'hFF, STUFF_BYTE=8'h00 and EOI_CODE=8'hD9.
REQ-032 The block SHALL be a single module with no sub-module; the FIFO is instantiated alongside it by the parent.
REQ-033 All state, word, idx and eoi_pending SHALL be registers. Outputs SHALL be decoded from registered state only (Moore).

Verification
REQ-034 FIFO word 0x12345678 with byte_ready=1 SHALL produce bytes 12,34,56,78 on consecutive cycles, with read_req pulsed once.
REQ-035 Word 0xFF00FFAB SHALL produce FF,00,00,FF,00,AB (6 transfers), with idx ending at 3 and returning to IDLE.
REQ-036 Word 0xAABBCCFF SHALL produce AA,BB,CC,FF,00; the stuff byte after the last byte SHALL complete before the next read_req.
REQ-037 byte_ready held low for 5 cycles mid-word SHALL leave byte_out/byte_valid unchanged, and the sequence SHALL resume without loss.
REQ-038 eoi_req pulsed while 2 words are queued SHALL produce all 8 data bytes, then FF,D9, then a single-cycle eoi_done. A second eoi_req during draining SHALL produce no extra marker.
REQ-039 rst asserted while in SEND with idx=1 SHALL force byte_valid=0 and IDLE at once. A following word 0x01020304 SHALL emit cleanly from 01.
